// File: rtl/prbs31_pkg.sv
// Shared types, constants and the PRBS31 (x^31 + x^28 + 1) predictor
// used by the serial PRBS31 checker.
package prbs31_pkg;

    localparam int unsigned PRBS_LEN = 31;
    localparam int unsigned TAP_A    = 30;
    localparam int unsigned TAP_B    = 27;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } prbs_state_e;

    // s[0] is the newest bit; the next bit is b[n-28] ^ b[n-31].
    function automatic logic prbs31_next(input logic [PRBS_LEN-1:0] s);
        return s[TAP_A] ^ s[TAP_B];
    endfunction

endpackage

// File: rtl/prbs31_err_window.sv
// Loss-of-lock observation window: counts valid bits and errors inside a
// WIN_LEN-bit window and flags loss when LOSS_THRESH errors land in one window.
// loss is combinational on the current bit so the owner can leave LOCKED on
// the same edge that samples the offending error.
module prbs31_err_window #(
    parameter int unsigned WIN_LEN     = 1024,
    parameter int unsigned LOSS_THRESH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic valid,
    input  logic err,
    output logic loss
);

    localparam int unsigned BW = $clog2(WIN_LEN + 1);
    localparam int unsigned EW = $clog2(LOSS_THRESH + 1);

    logic [BW-1:0] win_bits_q, win_bits_d;
    logic [EW-1:0] win_err_q, win_err_d;
    logic [EW-1:0] err_sum;

    // Next window counts; the error on the closing bit is judged against the old window.
    always_comb begin
        win_bits_d = win_bits_q;
        win_err_d  = win_err_q;
        err_sum    = win_err_q + EW'(err);
        loss       = 1'b0;
        if (clear) begin
            win_bits_d = '0;
            win_err_d  = '0;
        end else if (valid) begin
            loss = (err_sum >= EW'(LOSS_THRESH));
            if (win_bits_q == BW'(WIN_LEN - 1)) begin
                win_bits_d = '0;
                win_err_d  = '0;
            end else begin
                win_bits_d = win_bits_q + BW'(1);
                win_err_d  = err_sum;
            end
        end
    end

    // Window counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_bits_q <= '0;
            win_err_q  <= '0;
        end else begin
            win_bits_q <= win_bits_d;
            win_err_q  <= win_err_d;
        end
    end

endmodule

// File: rtl/prbs31_checker.sv
// Serial PRBS31 checker: hunts/self-synchronises to the incoming stream,
// locks after LOCK_THRESH consecutive correct predictions, then counts errors
// against a free-running predictor and drops lock on too many errors per window.
// Optional macro PRBS31_CHK_BITCNT_EN adds a saturating bit_count output.
module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int unsigned LOCK_THRESH = 64,
    parameter int unsigned WIN_LEN     = 1024,
    parameter int unsigned LOSS_THRESH = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state_o
`ifdef PRBS31_CHK_BITCNT_EN
    ,
    output logic [31:0]      bit_count
`endif
);

    localparam int unsigned FILL_W  = $clog2(PRBS_LEN + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_THRESH + 1);

    prbs_state_e         state_q, state_d;
    logic [PRBS_LEN-1:0] s_q, s_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;

    logic pred;
    logic in_locked;
    logic err_hit;
    logic win_loss;

    assign pred      = prbs31_next(s_q);
    assign in_locked = (state_q == LOCKED);
    assign err_hit   = bit_valid && in_locked && (bit_in != pred);

    prbs31_err_window #(
        .WIN_LEN    (WIN_LEN),
        .LOSS_THRESH(LOSS_THRESH)
    ) u_err_window (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(!in_locked),
        .valid(bit_valid),
        .err  (err_hit),
        .loss (win_loss)
    );

    // Next-state, shift register, match/fill counters and error accounting.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        fill_d      = fill_q;
        match_d     = match_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;
        if (bit_valid) begin
            case (state_q)
                HUNT: begin
                    s_d    = {s_q[PRBS_LEN-2:0], bit_in};
                    fill_d = fill_q + FILL_W'(1);
                    if (fill_d == FILL_W'(PRBS_LEN)) begin
                        state_d = SYNC;
                        match_d = '0;
                    end
                end
                SYNC: begin
                    // Raw load keeps the register aligned to the line; all-zero never matches.
                    s_d = {s_q[PRBS_LEN-2:0], bit_in};
                    if ((bit_in == pred) && (s_q != '0)) begin
                        match_d = match_q + MATCH_W'(1);
                    end else begin
                        match_d = '0;
                    end
                    if (match_d == MATCH_W'(LOCK_THRESH)) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    // Predictor free-runs so a single flipped bit yields a single error.
                    s_d = {s_q[PRBS_LEN-2:0], pred};
                    if (err_hit) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                    end
                    if (win_loss) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end
                end
                default: ;
            endcase
        end
        if (clr_cnt) begin
            err_count_d = '0;
        end
        locked_d = (state_d == LOCKED);
    end

    // Checker state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            s_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign state_o   = state_q;

`ifdef PRBS31_CHK_BITCNT_EN
    logic [31:0] bit_count_q, bit_count_d;

    // Saturating count of valid bits seen while locked; cleared with err_count.
    always_comb begin
        bit_count_d = bit_count_q;
        if (bit_valid && in_locked && (bit_count_q != '1)) begin
            bit_count_d = bit_count_q + 32'd1;
        end
        if (clr_cnt) begin
            bit_count_d = '0;
        end
    end

    // Bit counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_count_q <= '0;
        end else begin
            bit_count_q <= bit_count_d;
        end
    end

    assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
// Self-checking bench for prbs31_checker: a queue-based reference model drives
// expectations for the default instance; a second instance with CNT_W=4 checks
// error-count saturation in parallel.
`timescale 1ns/1ps
module tb_prbs31_checker;

    localparam int unsigned LOCK_THRESH = 64;
    localparam int unsigned WIN_LEN     = 1024;
    localparam int unsigned LOSS_THRESH = 16;
    localparam int unsigned SEQ_LEN     = 40000;
    localparam longint      A_CNT_MAX   = 65535;
    localparam longint      BC_MAX      = 64'hFFFF_FFFF;
    localparam int          NO_EVENT    = -1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, bit_in, bit_valid, clr_cnt, locked, err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state_o;
    logic        s_rst_n, s_bit_in, s_bit_valid, s_clr_cnt, s_locked, s_err_pulse;
    logic [3:0]  s_err_count;
    logic [1:0]  s_state_o;
`ifdef PRBS31_CHK_BITCNT_EN
    logic [31:0] bit_count, s_bit_count;
`endif

    prbs31_checker #(
        .LOCK_THRESH(LOCK_THRESH), .WIN_LEN(WIN_LEN), .LOSS_THRESH(LOSS_THRESH), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state_o(state_o)
`ifdef PRBS31_CHK_BITCNT_EN
        , .bit_count(bit_count)
`endif
    );

    prbs31_checker #(
        .LOCK_THRESH(LOCK_THRESH), .WIN_LEN(WIN_LEN), .LOSS_THRESH(LOSS_THRESH), .CNT_W(4)
    ) dut_sat (
        .clk(clk), .rst_n(s_rst_n), .bit_in(s_bit_in), .bit_valid(s_bit_valid), .clr_cnt(s_clr_cnt),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count), .state_o(s_state_o)
`ifdef PRBS31_CHK_BITCNT_EN
        , .bit_count(s_bit_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference PRBS31 stream: seed 31'b1 (newest bit = 1), b[n] = b[n-28] ^ b[n-31].
    bit prbs [0:SEQ_LEN+30];

    function automatic bit gen(input int k);
        return prbs[k+31];
    endfunction

    // ---------------- reference model for the default instance ----------------
    int     m_state;              // 0 HUNT, 1 SYNC, 2 LOCKED
    int     m_fill, m_match, m_wbits, m_werr;
    bit     m_hist[$];            // last 31 line/predicted bits, oldest first
    longint m_errcnt, m_bitcnt;
    bit     m_pulse;

    int ka, a_vcount, a_sync_at, a_lock_at, a_pulses, a_max_state;
    bit a_lock_seen;

    function automatic void model_reset();
        m_state = 0; m_fill = 0; m_match = 0; m_wbits = 0; m_werr = 0;
        m_errcnt = 0; m_bitcnt = 0; m_pulse = 0;
        m_hist.delete();
        for (int i = 0; i < 31; i++) m_hist.push_back(1'b0);
        a_vcount = 0; a_sync_at = NO_EVENT; a_lock_at = NO_EVENT;
        a_pulses = 0; a_max_state = 0; a_lock_seen = 0;
    endfunction

    function automatic void hist_push(input bit b);
        m_hist.push_back(b);
        void'(m_hist.pop_front());
    endfunction

    function automatic void model_step(input bit b, input bit v, input bit c);
        bit p;
        bit any;
        m_pulse = 0;
        if (v) begin
            p   = m_hist[0] ^ m_hist[3];     // b[n-31] ^ b[n-28]
            any = 0;
            foreach (m_hist[i]) any |= m_hist[i];
            case (m_state)
                0: begin
                    hist_push(b);
                    m_fill++;
                    if (m_fill == 31) begin m_state = 1; m_match = 0; end
                end
                1: begin
                    if (b == p && any) m_match++; else m_match = 0;
                    hist_push(b);
                    if (m_match == LOCK_THRESH) begin m_state = 2; m_wbits = 0; m_werr = 0; end
                end
                default: begin
                    hist_push(p);
                    m_wbits++;
                    if (m_bitcnt < BC_MAX) m_bitcnt++;
                    if (b != p) begin
                        m_pulse = 1;
                        if (m_errcnt < A_CNT_MAX) m_errcnt++;
                        m_werr++;
                    end
                    if (m_werr >= LOSS_THRESH) begin m_state = 0; m_fill = 0; end
                    if (m_wbits == WIN_LEN) begin m_wbits = 0; m_werr = 0; end
                end
            endcase
        end
        if (c) begin m_errcnt = 0; m_bitcnt = 0; end
    endfunction

    task automatic cyc_a(input bit b, input bit v, input bit c);
        bit_in = b; bit_valid = v; clr_cnt = c;
        @(posedge clk);
        model_step(b, v, c);
        #1;
        if (v) a_vcount++;
        if (err_pulse === 1'b1) a_pulses++;
        if (state_o === 2'd1 && a_sync_at == NO_EVENT) a_sync_at = a_vcount;
        if (locked === 1'b1 && a_lock_at == NO_EVENT) a_lock_at = a_vcount;
        if (locked === 1'b1) a_lock_seen = 1;
        if (int'(state_o) > a_max_state) a_max_state = int'(state_o);
        check("state_o", state_o, m_state);
        check("locked", locked, m_state == 2);
        check("err_pulse", err_pulse, m_pulse);
        check("err_count", err_count, m_errcnt);
`ifdef PRBS31_CHK_BITCNT_EN
        check("bit_count", bit_count, m_bitcnt);
`endif
    endtask

    task automatic send_a(input bit flip, input bit v, input bit c);
        bit b;
        if (v) begin b = gen(ka) ^ flip; ka++; end
        else b = 1'($urandom);
        cyc_a(b, v, c);
    endtask

    task automatic reset_a();
        rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clr_cnt = 1'b0;
        model_reset();
        ka = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state_o", state_o, 0);
        check("rst_locked", locked, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_count", err_count, 0);
`ifdef PRBS31_CHK_BITCNT_EN
        check("rst_bit_count", bit_count, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_a();
        // Clean stream: SYNC after 31 bits, LOCKED after 95.
        reset_a();
        repeat (95) send_a(0, 1, 0);
        check("sync_point", a_sync_at, 31);
        check("lock_point", a_lock_at, 95);
        repeat (5000) send_a(0, 1, 0);
        check("clean_err_count", err_count, 0);
        check("clean_locked", locked, 1);

        // Single flipped bit.
        a_pulses = 0;
        send_a(1, 1, 0);
        repeat (40) send_a(0, 1, 0);
        check("single_pulses", a_pulses, 1);
        check("single_err_count", err_count, 1);
        check("single_locked", locked, 1);

        // Loss of lock: 16 errors inside one fresh window.
        send_a(0, 1, 1);
        check("clr_err_count", err_count, 0);
        for (int i = 0; i < 1100 && m_wbits != 0; i++) send_a(0, 1, 0);
        for (int e = 1; e <= 16; e++) begin
            check("loss_pre_locked", locked, 1);
            send_a(1, 1, 0);
            if (e < 16) repeat ($urandom_range(3, 0)) send_a(0, 1, 0);
        end
        check("loss_locked", locked, 0);
        check("loss_state", state_o, 0);
        check("loss_err_count", err_count, 16);
        a_vcount = 0; a_lock_at = NO_EVENT;
        for (int i = 0; i < 200 && a_lock_at == NO_EVENT; i++) send_a(0, 1, 0);
        check("relock_point", a_lock_at, 95);

        // Stuck-at-0 line never locks.
        reset_a();
        repeat (5000) cyc_a(0, 1, 0);
        check("stuck_max_state", a_max_state, 1);
        check("stuck_lock_seen", a_lock_seen, 0);
        check("stuck_err_count", err_count, 0);

        // Random gaps in bit_valid, then clr_cnt against errors.
        reset_a();
        for (int i = 0; i < 1000 && a_lock_at == NO_EVENT; i++) send_a(0, 1'($urandom_range(1, 0)), 0);
        check("gap_lock_point", a_lock_at, 95);
        repeat (200) send_a(0, 1'($urandom_range(1, 0)), 0);
        check("gap_err_count", err_count, 0);
        send_a(1, 1, 0);
        check("gap_err_one", err_count, 1);
        repeat (20) send_a(0, 1, 0);
        send_a(1, 1, 1);
        check("clr_with_err_count", err_count, 0);
        check("clr_with_err_pulse", err_pulse, 1);
        send_a(1, 1, 0);
        send_a(0, 0, 1);
        check("clr_idle_count", err_count, 0);
        check("clr_idle_pulse", err_pulse, 0);

        // Asynchronous reset while locked, then resync from HUNT mid-stream.
        send_a(1, 1, 0);
        repeat (5) send_a(0, 1, 0);
        check("pre_areset_locked", locked, 1);
        check("pre_areset_count", err_count, 1);
        bit_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("areset_locked", locked, 0);
        check("areset_state", state_o, 0);
        check("areset_count", err_count, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200 && a_lock_at == NO_EVENT; i++) send_a(0, 1, 0);
        check("areset_relock_point", a_lock_at, 95);
    endtask

    // ---------------- saturation instance (CNT_W = 4) ----------------
    int kb;
    longint b_locked_bits;

    task automatic cyc_b(input bit b, input bit v);
        s_bit_in = b; s_bit_valid = v; s_clr_cnt = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input bit flip, input bit v);
        bit b;
        if (v) begin
            b = gen(kb) ^ flip;
            kb++;
            if (s_locked === 1'b1) b_locked_bits++;
        end else b = 1'($urandom);
        cyc_b(b, v);
    endtask

    task automatic run_b();
        bit v;
        s_rst_n = 1'b0; s_bit_in = 1'b0; s_bit_valid = 1'b0; s_clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("sat_rst_count", s_err_count, 0);
        check("sat_rst_state", s_state_o, 0);
        @(negedge clk);
        s_rst_n = 1'b1;
        kb = 0; b_locked_bits = 0;
        for (int i = 0; i < 1000 && s_locked !== 1'b1; i++) send_b(0, $urandom_range(3, 0) != 0);
        check("sat_lock", s_locked, 1);
        for (int e = 1; e <= 20; e++) begin
            send_b(1, 1);
            check("sat_pulse", s_err_pulse, 1);
            check("sat_err_count", s_err_count, (e < 15) ? e : 15);
            check("sat_locked", s_locked, 1);
            for (int n = 0; n < 1100; ) begin
                v = ($urandom_range(3, 0) != 0);
                send_b(0, v);
                if (v) n++;
            end
        end
        check("sat_final_count", s_err_count, 15);
        check("sat_final_locked", s_locked, 1);
`ifdef PRBS31_CHK_BITCNT_EN
        check("sat_bit_count", s_bit_count, b_locked_bits);
`endif
    endtask

    initial begin
        for (int n = 0; n < 31; n++) prbs[n] = (n == 30);
        for (int n = 31; n < SEQ_LEN + 31; n++) prbs[n] = prbs[n-28] ^ prbs[n-31];
        fork
            run_a();
            run_b();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
